// File: rtl/barrel_shift_arbiter.sv
// Two-port round-robin front end sharing one 8-bit rotate unit, with a registered result slot.
// Latency: 1 cycle from accept edge to out_valid; 1 result/cycle when out_ready is held high.
// Backpressure: a full slot with out_ready low deasserts both readys and freezes result and grant history.

// Purely combinational rotate unit: sel=1 rotates right, sel=0 rotates left, bits wrap.
module barrel_shifter #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  amt,
    input  logic              sel,
    output logic [DATA_W-1:0] data_out
);
    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] rot_r;
    logic [2*DATA_W-1:0] rot_l;

    // Rotating a doubled copy of the operand gives the wrap-around for free.
    always_comb begin
        dbl      = {data_in, data_in};
        rot_r    = dbl >> amt;
        rot_l    = dbl << amt;
        data_out = sel ? rot_r[DATA_W-1:0] : rot_l[2*DATA_W-1:DATA_W];
    end
endmodule

module barrel_shift_arbiter #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic [AMT_W-1:0]  a_amt,
    input  logic              a_sel,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic [AMT_W-1:0]  b_amt,
    input  logic              b_sel,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    input  logic              out_ready
);
    // Requester IDs as they appear on out_id and in the grant history.
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_id_q,    out_id_d;
    logic              last_grant_q, last_grant_d;

    logic              slot_free;
    logic              gnt_vld;
    logic              gnt_id;
    logic              accept;
    logic [DATA_W-1:0] shf_data;
    logic [AMT_W-1:0]  shf_amt;
    logic              shf_sel;
    logic [DATA_W-1:0] shf_res;

    // Round-robin grant: a lone requester wins; under contention the one not served last wins.
    always_comb begin
        gnt_vld = a_valid || b_valid;
        gnt_id  = ID_A;
        if (a_valid && b_valid) begin
            gnt_id = ~last_grant_q;
        end else if (b_valid) begin
            gnt_id = ID_B;
        end
    end

    // The slot can take a new result when empty or when it is drained in the same cycle.
    // Readys are gated by rst_n so nothing is acknowledged while reset is held.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        accept    = rst_n && slot_free && gnt_vld;
        a_ready   = accept && (gnt_id == ID_A);
        b_ready   = accept && (gnt_id == ID_B);
    end

    // Steer the granted requester's operand into the single shared shifter.
    always_comb begin
        shf_data = (gnt_id == ID_B) ? b_data : a_data;
        shf_amt  = (gnt_id == ID_B) ? b_amt  : a_amt;
        shf_sel  = (gnt_id == ID_B) ? b_sel  : a_sel;
    end

    barrel_shifter #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_shifter (
        .data_in  (shf_data),
        .amt      (shf_amt),
        .sel      (shf_sel),
        .data_out (shf_res)
    );

    // Next slot contents: load on accept, empty on drain-only, otherwise hold.
    // Data and ID are left untouched on drain; they are don't-care once out_valid drops.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = shf_res;
            out_id_d     = gnt_id;
            last_grant_d = gnt_id;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    // Slot and grant-history registers; last_grant resets to B so A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= ID_A;
            last_grant_q <= ID_B;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: directed scenarios plus randomized traffic.
// Expected values come from a transaction-level model of the result slot and grant order.
// Inputs are driven after the falling edge and outputs sampled 1 time unit later.
module tb_barrel_shift_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, a_sel, b_sel, a_ready, b_ready;
    logic [7:0] a_data, b_data, out_data;
    logic [2:0] a_amt, b_amt;
    logic       out_valid, out_id, out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot contents and which requester was served most recently.
    logic       m_vld;
    logic [7:0] m_dat;
    logic       m_id;
    logic       m_last;

    barrel_shift_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_amt     (a_amt),
        .a_sel     (a_sel),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_amt     (b_amt),
        .b_sel     (b_sel),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Rotation by arithmetic on an integer: right keeps the low byte of (d*257)>>n,
    // left keeps the high byte of (d*257)<<n.
    function automatic logic [7:0] rot(input logic [7:0] d, input int n, input logic right);
        int unsigned x;
        x = int'(d) * 257;
        if (right) return 8'((x >> n) & 32'hFF);
        return 8'(((x << n) >> 8) & 32'hFF);
    endfunction

    task automatic model_reset();
        m_vld  = 1'b0;
        m_dat  = 8'h00;
        m_id   = 1'b0;
        m_last = 1'b1;
    endtask

    // One clock cycle: apply inputs, check against the model, advance both across the rising edge.
    task automatic cycle(input logic av, input logic [7:0] ad, input logic [2:0] aa, input logic as_,
                         input logic bv, input logic [7:0] bd, input logic [2:0] ba, input logic bs,
                         input logic ordy, output logic acc_a, output logic acc_b);
        logic free, win;
        a_valid = av; a_data = ad; a_amt = aa; a_sel = as_;
        b_valid = bv; b_data = bd; b_amt = ba; b_sel = bs;
        out_ready = ordy;
        free  = !m_vld || ordy;
        win   = (av && bv) ? !m_last : bv;
        acc_a = free && av && !win;
        acc_b = free && bv && win;
        #1;
        chk("a_ready", a_ready, acc_a);
        chk("b_ready", b_ready, acc_b);
        chk("out_valid", out_valid, m_vld);
        if (m_vld) begin
            chk("out_data", out_data, m_dat);
            chk("out_id", out_id, m_id);
        end
        @(posedge clk);
        if (acc_a) begin
            m_vld = 1'b1; m_dat = rot(ad, int'(aa), as_); m_id = 1'b0; m_last = 1'b0;
        end else if (acc_b) begin
            m_vld = 1'b1; m_dat = rot(bd, int'(ba), bs); m_id = 1'b1; m_last = 1'b1;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    logic       ra, rb, prev_id;
    logic [7:0] hold_dat;
    logic       pa, pb;
    logic [7:0] pad, pbd;
    logic [2:0] paa, pba;
    logic       pas, pbs;

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b1; a_data = 8'hA5; a_amt = 3'd1; a_sel = 1'b0;
        b_valid = 1'b1; b_data = 8'h5A; b_amt = 3'd2; b_sel = 1'b1;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_id", out_id, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // A only: rotate right by 1.
        cycle(1, 8'b10110110, 3'd1, 1, 0, 8'h00, 3'd0, 0, 1, ra, rb);
        chk("tp_a_only_data", out_data, 8'b01011011);
        chk("tp_a_only_id", out_id, 1'b0);
        // B only: rotate right by 4.
        cycle(0, 8'h00, 3'd0, 0, 1, 8'b11110000, 3'd4, 1, 1, ra, rb);
        chk("tp_b_only_data", out_data, 8'b00001111);
        chk("tp_b_only_id", out_id, 1'b1);

        // Contention: A first (last grant was B), then B on the following cycle.
        cycle(1, 8'b10001110, 3'd2, 0, 1, 8'b00000001, 3'd7, 0, 1, ra, rb);
        chk("tp_cont1_data", out_data, 8'b00111010);
        chk("tp_cont1_id", out_id, 1'b0);
        cycle(0, 8'h00, 3'd0, 0, 1, 8'b00000001, 3'd7, 0, 1, ra, rb);
        chk("tp_cont2_data", out_data, 8'b10000000);
        chk("tp_cont2_id", out_id, 1'b1);
        cycle(1, 8'h3C, 3'd3, 1, 1, 8'hC3, 3'd5, 0, 1, ra, rb);
        chk("tp_cont3_id", out_id, 1'b0);
        chk("tp_cont3_acc_b", rb, 1'b0);

        // Backpressure for 3 cycles with both requesters valid: slot frozen.
        hold_dat = out_data;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 8'h11, 3'd1, 0, 1, 8'h81, 3'd6, 1, 0, ra, rb);
            chk("bp_data_stable", out_data, hold_dat);
            chk("bp_id_stable", out_id, 1'b0);
        end
        // Release: accept happens in the same cycle as the drain (B, since A went last).
        cycle(1, 8'h11, 3'd1, 0, 1, 8'h81, 3'd6, 1, 1, ra, rb);
        chk("bp_release_id", out_id, 1'b1);
        chk("bp_release_data", out_data, rot(8'h81, 6, 1'b1));
        cycle(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1, ra, rb);

        // Asynchronous reset mid-cycle while a result is pending.
        cycle(1, 8'hF0, 3'd0, 0, 0, 8'h00, 3'd0, 0, 0, ra, rb);
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_a_ready", a_ready, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous contention with amt=0: ids alternate from A, data passes through unchanged.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 8'(8'h10 + i), 3'd0, i[0], 1, 8'(8'hE0 + i), 3'd0, !i[0], 1, ra, rb);
            chk("alt_id", out_id, i[0]);
            chk("amt0_data", out_data, i[0] ? 8'(8'hE0 + i) : 8'(8'h10 + i));
        end
        cycle(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1, ra, rb);

        // Randomized traffic; each requester holds its command until accepted.
        pa = 0; pb = 0;
        pad = 0; pbd = 0; paa = 0; pba = 0; pas = 0; pbs = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && ($urandom_range(0, 3) != 0)) begin
                pa = 1; pad = 8'($urandom); paa = 3'($urandom); pas = 1'($urandom);
            end
            if (!pb && ($urandom_range(0, 3) != 0)) begin
                pb = 1; pbd = 8'($urandom); pba = 3'($urandom); pbs = 1'($urandom);
            end
            cycle(pa, pad, paa, pas, pb, pbd, pba, pbs, ($urandom_range(0, 2) != 0), ra, rb);
            if (ra) pa = 0;
            if (rb) pb = 0;
        end
        cycle(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1, ra, rb);
        cycle(0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1, ra, rb);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
